// File: rtl/mux_arbiter_pkg.sv
// Shared types for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_X = 2'd1,
    GRANT_Y = 2'd2
  } state_t;

  // Also used directly as the selector encoding: 0 picks X, 1 picks Y.
  typedef enum logic {
    OWN_X = 1'b0,
    OWN_Y = 1'b1
  } owner_t;

  // Hold counter width: max(1, clog2(max_hold)).
  function automatic int cnt_w(input int max_hold);
    return (max_hold <= 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Requester/bus bundle between the two sources and the shared output bus.
interface mux_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_x;
  logic             req_y;
  logic [WIDTH-1:0] data_x;
  logic [WIDTH-1:0] data_y;
  logic             gnt_x;
  logic             gnt_y;
  logic             sel;
  logic [WIDTH-1:0] m_out;
  logic             m_valid;

  // Requester side: drives requests and words, observes grants and the bus.
  modport master (
    output req_x, req_y, data_x, data_y,
    input  gnt_x, gnt_y, sel, m_out, m_valid
  );

  // Arbiter side.
  modport slave (
    input  req_x, req_y, data_x, data_y,
    output gnt_x, gnt_y, sel, m_out, m_valid
  );
endinterface

// File: rtl/mux_arbiter_hold_counter.sv
// Saturating tenure counter: counts grant cycles, parks at MAX_HOLD-1.
module hold_counter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CW       = cnt_w(MAX_HOLD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          term
);

  localparam logic [CW-1:0] TERM = CW'(MAX_HOLD - 1);

  assign term = (cnt == TERM);

  // Clear wins over count so a new tenure always starts at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning a shared WIDTH-bit 2:1 selector and output register.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);

  localparam int CW = cnt_w(MAX_HOLD);

  state_t           state, nxt;
  owner_t           last;
  owner_t           sel_q;
  logic             gnt_x_q, gnt_y_q;
  logic [WIDTH-1:0] m_out_q;
  logic             m_valid_q;
  logic             entry;
  logic             term;
  logic [CW-1:0]    cnt;
  logic             own_req;
  logic [WIDTH-1:0] word;

  hold_counter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (entry),
    .enable (state != IDLE),
    .cnt    (cnt),
    .term   (term)
  );

  // Next-state decision from the requests present at this edge.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_x && bus.req_y) nxt = (last == OWN_Y) ? GRANT_X : GRANT_Y;
        else if (bus.req_x)         nxt = GRANT_X;
        else if (bus.req_y)         nxt = GRANT_Y;
      end
      GRANT_X: begin
        if (!bus.req_x)             nxt = bus.req_y ? GRANT_Y : IDLE;
        else if (bus.req_y && term) nxt = GRANT_Y;
      end
      GRANT_Y: begin
        if (!bus.req_y)             nxt = bus.req_x ? GRANT_X : IDLE;
        else if (bus.req_x && term) nxt = GRANT_X;
      end
      default: nxt = IDLE;
    endcase
  end

  // A new tenure starts whenever we move into a grant state (incl. direct handoff).
  assign entry = (nxt != state) && (nxt != IDLE);

  // Word only counts as valid while its owner is still asking for the bus.
  assign own_req = (gnt_x_q & bus.req_x) | (gnt_y_q & bus.req_y);
  assign word    = (sel_q == OWN_Y) ? bus.data_y : bus.data_x;

  // FSM state, round-robin memory, registered grant decodes and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= OWN_Y;
      gnt_x_q   <= 1'b0;
      gnt_y_q   <= 1'b0;
      sel_q     <= OWN_X;
      m_out_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state     <= nxt;
      if (entry) last <= (nxt == GRANT_Y) ? OWN_Y : OWN_X;
      gnt_x_q   <= (nxt == GRANT_X);
      gnt_y_q   <= (nxt == GRANT_Y);
      sel_q     <= (nxt == GRANT_Y) ? OWN_Y : OWN_X;
      m_valid_q <= own_req;
      m_out_q   <= own_req ? word : '0;
    end
  end

  assign bus.gnt_x   = gnt_x_q;
  assign bus.gnt_y   = gnt_y_q;
  assign bus.sel     = sel_q;
  assign bus.m_out   = m_out_q;
  assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench: MAX_HOLD=4 and MAX_HOLD=1 instances driven in lockstep.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_arbiter_if #(.WIDTH(8)) bus_a ();
  mux_arbiter_if #(.WIDTH(8)) bus_b ();

  mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  mux_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // {gnt_x, gnt_y, sel, m_valid, m_out}
  typedef logic [11:0] obs_t;

  obs_t qa[$];
  obs_t qb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference: owner 0=none 1=X 2=Y, last owner, cycles served this tenure.
  int own[2]  = '{0, 0};
  int last[2] = '{2, 2};
  int run[2]  = '{0, 0};

  function automatic obs_t model(input int i, input int mh, input logic r,
                                 input logic rx, input logic ry,
                                 input logic [7:0] dx, input logic [7:0] dy);
    logic       v;
    logic [7:0] mo;
    int         nw;
    if (r) begin
      own[i] = 0; last[i] = 2; run[i] = 0;
      return 12'h000;
    end
    v  = (own[i] == 1 && rx) || (own[i] == 2 && ry);
    mo = v ? ((own[i] == 2) ? dy : dx) : 8'h00;
    case (own[i])
      0:       nw = (rx && ry) ? ((last[i] == 2) ? 1 : 2) : (rx ? 1 : (ry ? 2 : 0));
      1:       nw = !rx ? (ry ? 2 : 0) : ((ry && run[i] + 1 >= mh) ? 2 : 1);
      default: nw = !ry ? (rx ? 1 : 0) : ((rx && run[i] + 1 >= mh) ? 1 : 2);
    endcase
    if (nw != 0 && nw != own[i]) begin
      run[i] = 0; last[i] = nw;
    end else if (own[i] != 0) begin
      run[i] = run[i] + 1;
    end
    own[i] = nw;
    return {nw == 1, nw == 2, nw == 2, v, mo};
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input logic r, input logic rx, input logic ry,
                      input logic [7:0] dx, input logic [7:0] dy);
    rst = r;
    bus_a.req_x = rx; bus_a.req_y = ry; bus_a.data_x = dx; bus_a.data_y = dy;
    bus_b.req_x = rx; bus_b.req_y = ry; bus_b.data_x = dx; bus_b.data_y = dy;
    qa.push_back(model(0, 4, r, rx, ry, dx, dy));
    qb.push_back(model(1, 1, r, rx, ry, dx, dy));
    @(posedge clk);
    #1;
    check("hold4", {bus_a.gnt_x, bus_a.gnt_y, bus_a.sel, bus_a.m_valid, bus_a.m_out}, qa.pop_front());
    check("hold1", {bus_b.gnt_x, bus_b.gnt_y, bus_b.sel, bus_b.m_valid, bus_b.m_out}, qb.pop_front());
  endtask

  initial begin
    // Reset held with both requesting: everything stays zero.
    repeat (3) step(1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A);

    // Lone X holds the bus indefinitely.
    repeat (14) step(1'b0, 1'b1, 1'b0, 8'hA5, 8'h00);

    // Contention from IDLE: X first, then 4/4 alternation (every cycle on hold1).
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (20) step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22);

    // Early release: X served 2 cycles then drops while Y waits.
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) step(1'b0, 1'b1, 1'b1, 8'h33, 8'h44);
    repeat (4) step(1'b0, 1'b0, 1'b1, 8'h33, 8'h44);

    // Reset during GRANT_Y, then both request: X wins first.
    step(1'b1, 1'b1, 1'b1, 8'h55, 8'h66);
    repeat (6) step(1'b0, 1'b1, 1'b1, 8'h55, 8'h66);

    // Both drop, then Y alone, then idle.
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h77, 8'h88);
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'h77, 8'h88);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h77, 8'h88);

    // Random traffic with occasional resets.
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit 2:1 selector path between two requesters, X and Y.
- Owns the select line and registers the selected word onto a shared output bus with a valid flag.
- A bounded hold counter limits how long either requester keeps ownership while the other waits.
- Sits between switch/input sources and the shared display/LED bus on the board-level datapath.

Parameters:
- WIDTH, 8, data width of each requester word and of m_out.
- MAX_HOLD, 4, maximum consecutive grant cycles while the other side is requesting; must be >= 1.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_x  in  1  requester X wants the bus.
- req_y  in  1  requester Y wants the bus.
- data_x  in  WIDTH  requester X word.
- data_y  in  WIDTH  requester Y word.
- gnt_x  out  1  X owns the bus (registered state decode).
- gnt_y  out  1  Y owns the bus (registered state decode).
- sel  out  1  selector control: 0 selects X, 1 selects Y; 0 when idle.
- m_out  out  WIDTH  registered selected word.
- m_valid  out  1  m_out holds a word from an active owner.

Behaviour:
- Reset values: state=IDLE, last=Y (so X wins the first tie), cnt=0, gnt_x=gnt_y=0, sel=0, m_out=0, m_valid=0. Reset overrides every request, including mid-grant.
- FSM states: IDLE, GRANT_X, GRANT_Y. Decisions use the request values sampled at the edge, so a grant appears 1 cycle after the request.
- IDLE:
  - Both requesting -> grant the side opposite last.
  - One requesting -> grant that side.
  - Neither -> stay in IDLE.
- GRANT_X (GRANT_Y is symmetric):
  - !req_x: go to GRANT_Y if req_y, else IDLE. Handoff has no idle gap.
  - req_x && req_y && cnt==MAX_HOLD-1: forced handoff to GRANT_Y.
  - Otherwise stay.
- cnt:
  - Cleared on every entry into a grant state.
  - Increments each cycle spent in a grant state.
  - Saturates at MAX_HOLD-1, so a lone requester keeps the bus indefinitely.
- last: updated to the new owner on every entry into a grant state.
- Output decodes: gnt_x = (state==GRANT_X), gnt_y = (state==GRANT_Y), sel = (state==GRANT_Y).
- Output register (1-cycle latency after grant), each edge:
  - m_out <= sel ? data_y : data_x while a grant state is active, else 0.
  - m_valid <= (gnt_x & req_x) | (gnt_y & req_y).
  - The cycle in which the owner drops its request yields m_valid=0 and m_out=0.
- Width: cnt is max(1,$clog2(MAX_HOLD)) bits. With MAX_HOLD=1, ownership alternates every cycle while both request.

Decomposition:
- Package mux_arb_pkg holds:
  - State enum typedef (IDLE, GRANT_X, GRANT_Y).
  - Owner typedef (OWN_X=0, OWN_Y=1), used for last and sel.
- One sub-module is natural: hold_counter (clear, enable, saturating at MAX_HOLD-1, flag at terminal count).
- The selector and output register stay inline.

Test Plan:
- Reset=1 for 3 cycles with req_x=req_y=1 -> gnt_x=gnt_y=0, sel=0, m_out=0x00, m_valid=0 throughout.
- Lone X: req_x=1, data_x=0xA5 from cycle 0 -> gnt_x=1 after edge 1; m_out=0xA5, m_valid=1 after edge 2; held for 12 cycles with no handoff.
- Contention from IDLE: both request, data_x=0x11, data_y=0x22, MAX_HOLD=4 -> grants alternate X,X,X,X,Y,Y,Y,Y,...; m_out follows the same pattern one cycle later; sel toggles every 4 cycles.
- Early release: X granted, Y requesting, X drops req after 2 grant cycles -> gnt_y=1 on the next edge, with no IDLE cycle; m_valid=0 for exactly one cycle, then m_out=data_y.
- Reset mid-operation: assert Reset during GRANT_Y -> next edge shows state IDLE, gnt_y=0, m_valid=0. After release with both requesting, X is granted first.
- MAX_HOLD=1 instance, both requesting -> gnt_x and gnt_y alternate every cycle; m_out alternates data_x/data_y with 1-cycle lag.
